mb_frame_writer: RTL and testbench
==================================

# mb_frame_writer

Macroblock-to-frame-store writer that sits directly upstream of the display backend. It accepts reconstructed 4:2:0 macroblock pixels, one byte per cycle, from the motion-compensation/IDCT sum stage. It packs four horizontally adjacent pixels into 32-bit ZBT words and writes them into the planar Y/Cb/Cr frame buffer that the backend scans out. It tracks raster macroblock position, computes ZBT word addresses, buffers words while the ZBT arbiter withholds grant, and signals frame completion.

## Interface

Parameters:
- WFIFO_DEPTH, 4, depth of the packed-word write FIFO (power of 2, ≥2)

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-high
- pic_width  in  12  luma width in pixels (multiple of 16)
- pic_height  in  12  luma height in pixels (multiple of 16)
- CB_start  in  19  ZBT word address of Cb plane
- CR_start  in  19  ZBT word address of Cr plane
- frame_start  in  1  one-cycle pulse; resets position to MB (0,0)
- pix_valid  in  1  pix_data valid
- pix_data  in  8  pixel byte
- pix_ready  out  1  pixel accepted when pix_valid & pix_ready
- zbt_we  out  1  write request, FIFO head valid
- zbt_addr  out  19  word address of head
- zbt_dataout  out  32  packed word of head
- zbt_grant  in  1  write performed in cycles where zbt_we & zbt_grant
- frame_done  out  1  one-cycle pulse after last word of frame written
- busy  out  1  FIFO non-empty or partial macroblock in progress

## Operation

- Macroblock order is raster: mb_col 0..pic_width/16−1, then mb_row++, up to pic_height/16−1.
- Within a MB, 384 bytes arrive in this block order: Y0 (TL), Y1 (TR), Y2 (BL), Y3 (BR), Cb, Cr. Each block is 8×8, row-major.
- Packing: first byte of a group of 4 goes to [31:24], last to [7:0]. Each block row produces 2 words.
- Y word address: (mb_row·16 + by·8 + r)·(pic_width/4) + mb_col·4 + bx·2 + w, where bx,by are the Y block quadrant, r is the row 0..7, and w is the word 0..1.
- Chroma word address: base + (mb_row·8 + r)·(pic_width/8) + mb_col·2 + w. base is CB_start or CR_start.
- Addresses are computed incrementally with adders (no multiplier). All arithmetic is 19-bit modulo.
- Each completed word is pushed with its address into the FIFO. Entries carry a last flag, set on the final Cr word of the final MB.
- Pixel counter is 9 bits (0..383) and block index 0..5. mb_col/mb_row wrap at 384 → next MB. After the last MB, position wraps to (0,0) automatically.
- frame_start clears the position counters and the partial word; queued FIFO entries are still written. If frame_start coincides with an accepted pixel, that pixel becomes pixel 0 of the new frame.

## Timing

- Reset values: zbt_we=0, zbt_addr=0, zbt_dataout=0, frame_done=0, busy=0, pix_ready=0. pix_ready=1 from the first clk edge after reset deasserts.
- Reset mid-frame discards the partial word, the FIFO contents and the position. No pending write is issued.
- The 4th byte accepted at edge N puts the word at the FIFO head. zbt_we/addr/dataout are valid after edge N+1 if the FIFO was empty.
- Outputs are registered from the FIFO head and are stable while zbt_we & !zbt_grant. A pop on grant presents the next entry in the following cycle, giving back-to-back writes.
- pix_ready = (FIFO count ≤ WFIFO_DEPTH−2), registered. No overflow is possible. Simultaneous push and pop in one cycle keeps the count unchanged.
- frame_done pulses in the cycle after the write of the last-flagged entry is granted.

## Configuration

- MBW_ZERO_SUBST_EN defined: any pixel byte 0x00 is written as 0x01, keeping 0x00 free as a reserved code for the YUV4 dump/display path.
- MBW_ZERO_SUBST_EN undefined: bytes are written unmodified.

## Test plan

- 720×480, CB_start=0x15180, CR_start=0x1A5E0. Stream MB(0,0) with ramp 0x10+i per block → first write addr 0x00000 data 0x10111213. Y0 row 1 writes addr 180. Y1 first word at addr 2. Y2 first word at addr 1440. Cb first word at 0x15180, Cb row 1 at 0x15180+90. Cr first word at 0x1A5E0.
- MB(1,0) Y0 first word at addr 4; its Cb at 0x15182. MB 45 = (0,1): Y at 2880, Cb at 0x15180+720.
- Hold zbt_grant=0 for 40 cycles while streaming → pix_ready falls after 3 words queued (DEPTH 4). On grant, all words are written in order with correct addresses and none lost.
- Full frame of 1350 MBs → exactly one frame_done pulse after the write to 0x1A5E0+21599. The next accepted pixel's word goes to addr 0.
- pix_data=0x00 everywhere: with the macro, data 0x01010101; without it, 0x00000000.
- Assert resetn mid-MB with 2 words queued → zbt_we=0 immediately. After release, frame_start plus a new MB writes from addr 0.

Source files
------------

// File: rtl/mb_frame_writer.sv
// Macroblock-to-frame-store writer: packs 4:2:0 MB pixels into 32-bit ZBT words with planar addresses.
// Optional MBW_ZERO_SUBST_EN: pixel byte 0x00 is written as 0x01 (0x00 reserved for the dump path).
module mb_frame_writer #(
   parameter int WFIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [11:0] pic_width,
   input  logic [11:0] pic_height,
   input  logic [18:0] CB_start,
   input  logic [18:0] CR_start,
   input  logic        frame_start,
   input  logic        pix_valid,
   input  logic [7:0]  pix_data,
   output logic        pix_ready,
   output logic        zbt_we,
   output logic [18:0] zbt_addr,
   output logic [31:0] zbt_dataout,
   input  logic        zbt_grant,
   output logic        frame_done,
   output logic        busy
);
   localparam int PW = $clog2(WFIFO_DEPTH);
   localparam int CW = PW + 1;

   logic [8:0]  pix_cnt_q, pix_cnt_d, pix_cnt_c;
   logic [7:0]  mb_col_q, mb_col_d, mb_col_c;
   logic [7:0]  mb_row_q, mb_row_d, mb_row_c;
   logic [18:0] y_col_q, y_col_d, y_col_c;
   logic [18:0] y_row_q, y_row_d, y_row_c;
   logic [18:0] c_row_q, c_row_d, c_row_c;
   logic [18:0] line_q, line_d, line_c;
   logic [23:0] word_q, word_d, word_c;
   logic [7:0]  pix_byte;
   logic [2:0]  blk;
   logic [18:0] stride, y_addr, c_addr;
   logic        accept, last_col, last_row, push;
   logic [51:0] push_ent;

   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [51:0]   mem_q [WFIFO_DEPTH];
   logic [51:0]   mem_d [WFIFO_DEPTH];
   logic [51:0]   head;
   logic          pop, out_vld;
   logic          zbt_we_q, zbt_we_d, zbt_last_q, zbt_last_d;
   logic [18:0]   zbt_addr_q, zbt_addr_d;
   logic [31:0]   zbt_data_q, zbt_data_d;
   logic          frame_done_q, frame_done_d, pix_ready_q, pix_ready_d;

   assign accept = pix_valid & pix_ready_q;

`ifdef MBW_ZERO_SUBST_EN
   assign pix_byte = (pix_data == 8'h00) ? 8'h01 : pix_data;
`else
   assign pix_byte = pix_data;
`endif

   always_comb begin
      // frame_start acts before the pixel accepted in the same cycle
      pix_cnt_c = frame_start ? 9'd0  : pix_cnt_q;
      mb_col_c  = frame_start ? 8'd0  : mb_col_q;
      mb_row_c  = frame_start ? 8'd0  : mb_row_q;
      y_col_c   = frame_start ? 19'd0 : y_col_q;
      y_row_c   = frame_start ? 19'd0 : y_row_q;
      c_row_c   = frame_start ? 19'd0 : c_row_q;
      line_c    = frame_start ? 19'd0 : line_q;
      word_c    = frame_start ? 24'd0 : word_q;

      blk      = pix_cnt_c[8:6];
      stride   = blk[2] ? {10'd0, pic_width[11:3]} : {9'd0, pic_width[11:2]};
      y_addr   = y_row_c + (blk[1] ? {6'd0, pic_width, 1'b0} : 19'd0) + y_col_c
               + {17'd0, blk[0], 1'b0} + line_c + {18'd0, pix_cnt_c[2]};
      c_addr   = (blk[0] ? CR_start : CB_start) + c_row_c + {1'b0, y_col_c[18:1]}
               + line_c + {18'd0, pix_cnt_c[2]};
      last_col = (mb_col_c == (pic_width[11:4] - 8'd1));
      last_row = ({mb_row_c, 4'hF} == (pic_height - 12'd1));
      push_ent = {(blk[2] ? c_addr : y_addr), word_c, pix_byte,
                  (pix_cnt_c == 9'd383) & last_col & last_row};

      pix_cnt_d = pix_cnt_c;
      mb_col_d  = mb_col_c;
      mb_row_d  = mb_row_c;
      y_col_d   = y_col_c;
      y_row_d   = y_row_c;
      c_row_d   = c_row_c;
      line_d    = line_c;
      word_d    = word_c;
      push      = 1'b0;

      if (accept) begin
         word_d = {word_c[15:0], pix_byte};
         push   = (pix_cnt_c[1:0] == 2'd3);
         if (pix_cnt_c[2:0] == 3'd7)
            line_d = (pix_cnt_c[5:3] == 3'd7) ? 19'd0 : line_c + stride;
         if (pix_cnt_c == 9'd383) begin
            pix_cnt_d = 9'd0;
            if (last_col) begin
               mb_col_d = 8'd0;
               y_col_d  = 19'd0;
               if (last_row) begin
                  mb_row_d = 8'd0;
                  y_row_d  = 19'd0;
                  c_row_d  = 19'd0;
               end else begin
                  mb_row_d = mb_row_c + 8'd1;
                  y_row_d  = y_row_c + {5'd0, pic_width, 2'b00};
                  c_row_d  = c_row_c + {7'd0, pic_width};
               end
            end else begin
               mb_col_d = mb_col_c + 8'd1;
               y_col_d  = y_col_c + 19'd4;
            end
         end else begin
            pix_cnt_d = pix_cnt_c + 9'd1;
         end
      end
   end

   always_comb begin
      pop      = zbt_we_q & zbt_grant;
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      cnt_d    = cnt_q + CW'(push) - CW'(pop);
      mem_d    = mem_q;
      if (push)
         mem_d[wr_ptr_q] = push_ent;
      // Output stage holds the post-edge head; an entry being written this edge is picked up next cycle
      head       = mem_q[rd_ptr_d];
      out_vld    = (cnt_d != '0) && !(push && (wr_ptr_q == rd_ptr_d));
      zbt_we_d   = out_vld;
      zbt_addr_d = out_vld ? head[51:33] : zbt_addr_q;
      zbt_data_d = out_vld ? head[32:1]  : zbt_data_q;
      zbt_last_d = out_vld & head[0];
      frame_done_d = pop & zbt_last_q;
      pix_ready_d  = (cnt_d <= CW'(WFIFO_DEPTH - 2));
   end

   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         pix_cnt_q    <= '0;
         mb_col_q     <= '0;
         mb_row_q     <= '0;
         y_col_q      <= '0;
         y_row_q      <= '0;
         c_row_q      <= '0;
         line_q       <= '0;
         word_q       <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         cnt_q        <= '0;
         zbt_we_q     <= 1'b0;
         zbt_addr_q   <= '0;
         zbt_data_q   <= '0;
         zbt_last_q   <= 1'b0;
         frame_done_q <= 1'b0;
         pix_ready_q  <= 1'b0;
      end else begin
         pix_cnt_q    <= pix_cnt_d;
         mb_col_q     <= mb_col_d;
         mb_row_q     <= mb_row_d;
         y_col_q      <= y_col_d;
         y_row_q      <= y_row_d;
         c_row_q      <= c_row_d;
         line_q       <= line_d;
         word_q       <= word_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         cnt_q        <= cnt_d;
         zbt_we_q     <= zbt_we_d;
         zbt_addr_q   <= zbt_addr_d;
         zbt_data_q   <= zbt_data_d;
         zbt_last_q   <= zbt_last_d;
         frame_done_q <= frame_done_d;
         pix_ready_q  <= pix_ready_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign pix_ready   = pix_ready_q;
   assign zbt_we      = zbt_we_q;
   assign zbt_addr    = zbt_addr_q;
   assign zbt_dataout = zbt_data_q;
   assign frame_done  = frame_done_q;
   assign busy        = (cnt_q != '0) || (pix_cnt_q != 9'd0);
endmodule

// File: tb/tb_mb_frame_writer.sv
// Directed self-checking bench for mb_frame_writer: addressing, packing, backpressure, frame end, reset.
module tb_mb_frame_writer;
   logic        clk = 1'b0;
   logic        resetn, frame_start, pix_valid, zbt_grant;
   logic [11:0] pic_width, pic_height;
   logic [18:0] CB_start, CR_start;
   logic [7:0]  pix_data;
   logic        pix_ready, zbt_we, frame_done, busy;
   logic [18:0] zbt_addr;
   logic [31:0] zbt_dataout;

   int vecs = 0;
   int errs = 0;
   logic [18:0] log_addr[$];
   logic [31:0] log_data[$];
   int          fd_cnt = 0;
   logic [18:0] fd_addr = '0;
   logic [18:0] last_addr = '0;

   mb_frame_writer #(.WFIFO_DEPTH(4)) dut (
      .clk(clk), .resetn(resetn), .pic_width(pic_width), .pic_height(pic_height),
      .CB_start(CB_start), .CR_start(CR_start), .frame_start(frame_start),
      .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
      .zbt_we(zbt_we), .zbt_addr(zbt_addr), .zbt_dataout(zbt_dataout),
      .zbt_grant(zbt_grant), .frame_done(frame_done), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (frame_done === 1'b1) begin
         fd_cnt  <= fd_cnt + 1;
         fd_addr <= last_addr;
      end
      if (zbt_we === 1'b1 && zbt_grant === 1'b1) begin
         log_addr.push_back(zbt_addr);
         log_data.push_back(zbt_dataout);
         last_addr <= zbt_addr;
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation still running at 1ms, required finish earlier");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int t = 0;
      while (pix_ready !== 1'b1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) chk("pix_ready_timeout", {31'd0, pix_ready}, 32'd1);
      pix_valid = 1'b1;
      pix_data  = b;
      @(negedge clk);
      pix_valid = 1'b0;
   endtask

   task automatic send_mb_ramp(input int first);
      for (int i = first; i < 384; i++) send_byte(8'(8'h10 + (i % 64)));
   endtask

   task automatic wait_log(input string tag, input int n);
      int t = 0;
      while (log_addr.size() < n && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk(tag, log_addr.size(), n);
   endtask

   task automatic pulse_frame_start();
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   task automatic log_chk(input string tag, input int idx, input logic [18:0] a, input logic [31:0] d,
                          input logic chk_data);
      if (idx >= log_addr.size()) begin
         chk({tag, "_missing"}, log_addr.size(), idx + 1);
      end else begin
         chk({tag, "_addr"}, {13'd0, log_addr[idx]}, {13'd0, a});
         if (chk_data) chk({tag, "_data"}, log_data[idx], d);
      end
   endtask

   initial begin
      int acc;
      int base;
      int sz;
      logic [31:0] zero_word;
      resetn = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; pix_data = 8'h00; zbt_grant = 1'b1;
      pic_width = 12'd720; pic_height = 12'd480; CB_start = 19'h15180; CR_start = 19'h1A5E0;
      repeat (3) @(negedge clk);
      chk("rst_we", {31'd0, zbt_we}, 32'd0);
      chk("rst_addr", {13'd0, zbt_addr}, 32'd0);
      chk("rst_data", zbt_dataout, 32'd0);
      chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_pix_ready", {31'd0, pix_ready}, 32'd0);
      resetn = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", {31'd0, pix_ready}, 32'd1);
      pulse_frame_start();

      // MB(0,0): first-word latency then the rest of the macroblock
      for (int i = 0; i < 4; i++) send_byte(8'(8'h10 + i));
      chk("lat_we_edgeN", {31'd0, zbt_we}, 32'd0);
      chk("busy_mid_mb", {31'd0, busy}, 32'd1);
      @(negedge clk);
      chk("lat_we_edgeN1", {31'd0, zbt_we}, 32'd1);
      chk("lat_addr", {13'd0, zbt_addr}, 32'd0);
      chk("lat_data", zbt_dataout, 32'h10111213);
      send_mb_ramp(4);
      wait_log("mb0_count", 96);
      log_chk("mb0_y0_w0", 0, 19'd0, 32'h10111213, 1'b1);
      log_chk("mb0_y0_w1", 1, 19'd1, 32'h14151617, 1'b1);
      log_chk("mb0_y0_r1", 2, 19'd180, 32'h18191A1B, 1'b1);
      log_chk("mb0_y1", 16, 19'd2, 32'h10111213, 1'b1);
      log_chk("mb0_y2", 32, 19'd1440, 32'h10111213, 1'b1);
      log_chk("mb0_y3", 48, 19'd1442, 32'h10111213, 1'b1);
      log_chk("mb0_cb", 64, 19'h15180, 32'h10111213, 1'b1);
      log_chk("mb0_cb_r1", 66, 19'h15180 + 19'd90, 32'h18191A1B, 1'b1);
      log_chk("mb0_cr", 80, 19'h1A5E0, 32'h10111213, 1'b1);
      log_chk("mb0_cr_last", 95, 19'h1A5E0 + 19'd631, 32'h4C4D4E4F, 1'b1);

      // MB(1,0)
      send_mb_ramp(0);
      wait_log("mb1_count", 192);
      log_chk("mb1_y0", 96, 19'd4, 32'h10111213, 1'b1);
      log_chk("mb1_y1", 112, 19'd6, 32'h10111213, 1'b1);
      log_chk("mb1_cb", 160, 19'h15182, 32'h10111213, 1'b1);

      // MB(2,0) under withheld grant
      zbt_grant = 1'b0;
      acc = 0;
      for (int c = 0; c < 40; c++) begin
         if (pix_ready === 1'b1) begin
            pix_valid = 1'b1;
            pix_data  = 8'(8'h10 + (acc % 64));
            acc++;
         end else begin
            pix_valid = 1'b0;
         end
         @(negedge clk);
      end
      pix_valid = 1'b0;
      chk("stall_bytes_accepted", acc, 12);
      chk("stall_pix_ready", {31'd0, pix_ready}, 32'd0);
      chk("stall_we", {31'd0, zbt_we}, 32'd1);
      chk("stall_addr", {13'd0, zbt_addr}, 32'd8);
      chk("stall_data", zbt_dataout, 32'h10111213);
      chk("stall_no_writes", log_addr.size(), 192);
      zbt_grant = 1'b1;
      send_mb_ramp(12);
      wait_log("mb2_count", 288);
      log_chk("mb2_w0", 192, 19'd8, 32'h10111213, 1'b1);
      log_chk("mb2_w1", 193, 19'd9, 32'h14151617, 1'b1);
      log_chk("mb2_w2", 194, 19'd188, 32'h18191A1B, 1'b1);
      log_chk("mb2_w3", 195, 19'd189, 32'h1C1D1E1F, 1'b1);
      chk("no_frame_done_yet", fd_cnt, 0);

      // Complete 32x32 frame (4 MBs)
      pic_width = 12'd32; pic_height = 12'd32; CB_start = 19'h100; CR_start = 19'h140;
      pulse_frame_start();
      base = log_addr.size();
      for (int m = 0; m < 4; m++) send_mb_ramp(0);
      wait_log("frame_count", base + 384);
      repeat (3) @(negedge clk);
      log_chk("sf_mb1_y0", base + 96, 19'd4, 32'h10111213, 1'b1);
      log_chk("sf_mb2_y0", base + 192, 19'd128, 32'h10111213, 1'b1);
      log_chk("sf_mb2_cb", base + 256, 19'h120, 32'h10111213, 1'b1);
      log_chk("sf_last", base + 383, 19'h17F, 32'h4C4D4E4F, 1'b1);
      chk("frame_done_count", fd_cnt, 1);
      chk("frame_done_after_addr", {13'd0, fd_addr}, 32'h17F);

      // Wrap to (0,0) and zero-byte handling
`ifdef MBW_ZERO_SUBST_EN
      zero_word = 32'h01010101;
`else
      zero_word = 32'h00000000;
`endif
      for (int i = 0; i < 4; i++) send_byte(8'h00);
      wait_log("wrap_count", base + 385);
      log_chk("wrap_zero", base + 384, 19'd0, zero_word, 1'b1);
      chk("frame_done_single", fd_cnt, 1);

      // Reset mid-MB with queued words
      zbt_grant = 1'b0;
      for (int i = 0; i < 10; i++) send_byte(8'h55);
      chk("pre_rst_we", {31'd0, zbt_we}, 32'd1);
      sz = log_addr.size();
      resetn = 1'b1;
      #1;
      chk("mid_rst_we", {31'd0, zbt_we}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_ready", {31'd0, pix_ready}, 32'd0);
      @(negedge clk);
      resetn = 1'b0;
      zbt_grant = 1'b1;
      @(negedge clk);
      send_byte(8'h77);
      send_byte(8'h77);
      frame_start = 1'b1;
      send_byte(8'hA0);
      frame_start = 1'b0;
      send_byte(8'hA1);
      send_byte(8'hA2);
      send_byte(8'hA3);
      wait_log("post_rst_count", sz + 1);
      repeat (5) @(negedge clk);
      log_chk("post_rst_word", sz, 19'd0, 32'hA0A1A2A3, 1'b1);
      chk("post_rst_no_stale", log_addr.size(), sz + 1);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
